// File: rtl/image_window_sequencer.sv
// Walks every 3x3 window of an image: fetches 9 pixels, pushes them to a filter slave,
// reads back the filter result and stores it. Optional macro: WINDOW_SEQ_CYCLE_COUNT_EN.
module image_window_sequencer #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] src_address,
  output logic              src_read,
  input  logic [31:0]       src_readdata,
  input  logic              src_waitrequest,
  output logic [4:0]        f_address,
  output logic              f_write,
  output logic [31:0]       f_writedata,
  output logic              f_read,
  input  logic [31:0]       f_readdata,
  input  logic              f_waitrequest,
  output logic [ADDR_W-1:0] dst_address,
  output logic              dst_write,
  output logic [31:0]       dst_writedata,
  input  logic              dst_waitrequest
`ifdef WINDOW_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  localparam logic [ADDR_W-1:0] L_W      = ADDR_W'(IMG_WIDTH);
  localparam logic [ADDR_W-1:0] L_OUT_W  = ADDR_W'(IMG_WIDTH - 2);
  localparam logic [ADDR_W-1:0] L_LAST_C = ADDR_W'(IMG_WIDTH - 3);
  localparam logic [ADDR_W-1:0] L_LAST_R = ADDR_W'(IMG_HEIGHT - 3);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PUSH, S_RESULT, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_row, r_col, w_row_nxt, w_col_nxt;
  logic [3:0]        r_k, w_k_nxt;
  logic [23:0]       r_pix, w_pix_nxt;
  logic [7:0]        r_res, w_res_nxt;
  logic              w_aborted_nxt;
  logic              w_busy_nxt, w_done_nxt;
  logic              w_src_read_nxt, w_f_write_nxt, w_f_read_nxt, w_dst_write_nxt;
  logic [ADDR_W-1:0] w_src_address_nxt, w_dst_address_nxt;
  logic [4:0]        w_f_address_nxt;
  logic [31:0]       w_f_writedata_nxt, w_dst_writedata_nxt;

  function automatic logic [ADDR_W-1:0] win_src_addr(input logic [ADDR_W-1:0] row,
                                                     input logic [ADDR_W-1:0] col,
                                                     input logic [3:0]        k);
    logic [ADDR_W-1:0] kr, kc;
    kr = ADDR_W'(k / 4'd3);
    kc = ADDR_W'(k % 4'd3);
    return (row + kr) * L_W + col + kc;
  endfunction

  // Next state, window indices and latched data; abort is honoured only on handshake completion.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_k_nxt       = r_k;
    w_pix_nxt     = r_pix;
    w_res_nxt     = r_res;
    w_aborted_nxt = aborted;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt   = S_FETCH;
          w_row_nxt     = '0;
          w_col_nxt     = '0;
          w_k_nxt       = 4'd0;
          w_aborted_nxt = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (!src_waitrequest) begin
          w_pix_nxt = src_readdata[23:0];
          if (abort) begin
            w_state_nxt   = S_IDLE;
            w_aborted_nxt = 1'b1;
          end else begin
            w_state_nxt = S_PUSH;
          end
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_PUSH: begin
        if (!f_waitrequest) begin
          if (abort) begin
            w_state_nxt   = S_IDLE;
            w_aborted_nxt = 1'b1;
          end else if (r_k < 4'd8) begin
            w_k_nxt     = r_k + 4'd1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_RESULT;
          end
        end else begin
          w_state_nxt = S_PUSH;
        end
      end
      S_RESULT: begin
        if (!f_waitrequest) begin
          w_res_nxt = f_readdata[7:0];
          if (abort) begin
            w_state_nxt   = S_IDLE;
            w_aborted_nxt = 1'b1;
          end else begin
            w_state_nxt = S_STORE;
          end
        end else begin
          w_state_nxt = S_RESULT;
        end
      end
      S_STORE: begin
        if (!dst_waitrequest) begin
          if (abort) begin
            w_state_nxt   = S_IDLE;
            w_aborted_nxt = 1'b1;
          end else begin
            w_state_nxt = S_NEXT;
          end
        end else begin
          w_state_nxt = S_STORE;
        end
      end
      S_NEXT: begin
        if (abort) begin
          w_state_nxt   = S_IDLE;
          w_aborted_nxt = 1'b1;
        end else begin
          w_k_nxt = 4'd0;
          if (r_col == L_LAST_C) begin
            w_col_nxt = '0;
            if (r_row == L_LAST_R) begin
              w_state_nxt = S_DONE;
            end else begin
              w_row_nxt   = r_row + {{(ADDR_W-1){1'b0}}, 1'b1};
              w_state_nxt = S_FETCH;
            end
          end else begin
            w_col_nxt   = r_col + {{(ADDR_W-1){1'b0}}, 1'b1};
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs derived from the next state so every strobe, address and data is a flop.
  always_comb begin
    w_busy_nxt          = (w_state_nxt != S_IDLE);
    w_done_nxt          = (w_state_nxt == S_DONE);
    w_src_read_nxt      = (w_state_nxt == S_FETCH);
    w_f_write_nxt       = (w_state_nxt == S_PUSH);
    w_f_read_nxt        = (w_state_nxt == S_RESULT);
    w_dst_write_nxt     = (w_state_nxt == S_STORE);
    w_src_address_nxt   = src_address;
    w_f_address_nxt     = f_address;
    w_f_writedata_nxt   = f_writedata;
    w_dst_address_nxt   = dst_address;
    w_dst_writedata_nxt = dst_writedata;
    case (w_state_nxt)
      S_FETCH:  w_src_address_nxt = win_src_addr(w_row_nxt, w_col_nxt, w_k_nxt);
      S_PUSH: begin
        w_f_address_nxt   = {1'b0, w_k_nxt};
        w_f_writedata_nxt = {8'h00, w_pix_nxt};
      end
      S_RESULT: w_f_address_nxt = 5'd0;
      S_STORE: begin
        w_dst_address_nxt   = w_row_nxt * L_OUT_W + w_col_nxt;
        w_dst_writedata_nxt = {24'h000000, w_res_nxt};
      end
      default:  w_src_address_nxt = src_address;
    endcase
  end

  // State, index and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_col         <= '0;
      r_k           <= 4'd0;
      r_pix         <= 24'd0;
      r_res         <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      src_read      <= 1'b0;
      src_address   <= '0;
      f_write       <= 1'b0;
      f_read        <= 1'b0;
      f_address     <= 5'd0;
      f_writedata   <= 32'd0;
      dst_write     <= 1'b0;
      dst_address   <= '0;
      dst_writedata <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_row         <= w_row_nxt;
      r_col         <= w_col_nxt;
      r_k           <= w_k_nxt;
      r_pix         <= w_pix_nxt;
      r_res         <= w_res_nxt;
      busy          <= w_busy_nxt;
      done          <= w_done_nxt;
      aborted       <= w_aborted_nxt;
      src_read      <= w_src_read_nxt;
      src_address   <= w_src_address_nxt;
      f_write       <= w_f_write_nxt;
      f_read        <= w_f_read_nxt;
      f_address     <= w_f_address_nxt;
      f_writedata   <= w_f_writedata_nxt;
      dst_write     <= w_dst_write_nxt;
      dst_address   <= w_dst_address_nxt;
      dst_writedata <= w_dst_writedata_nxt;
    end
  end

`ifdef WINDOW_SEQ_CYCLE_COUNT_EN
  // Saturating busy-cycle counter; value includes the current busy cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= 32'd0;
    end else if (r_state == S_IDLE && start && !abort) begin
      cycle_count <= 32'd1;
    end else if (w_busy_nxt && cycle_count != 32'hFFFF_FFFF) begin
      cycle_count <= cycle_count + 32'd1;
    end else begin
      cycle_count <= cycle_count;
    end
  end
`endif

endmodule

// File: tb/tb_image_window_sequencer.sv
// Randomised self-checking bench for image_window_sequencer (4x4 image) with memory and filter models.
module tb_image_window_sequencer;
  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic        busy, done, aborted;
  logic [15:0] src_address, dst_address;
  logic        src_read, src_waitrequest;
  logic [31:0] src_readdata;
  logic [4:0]  f_address;
  logic        f_write, f_read, f_waitrequest;
  logic [31:0] f_writedata, f_readdata;
  logic        dst_write, dst_waitrequest;
  logic [31:0] dst_writedata;
`ifdef WINDOW_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
  logic [31:0] cc_at_done;
`endif

  image_window_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .src_address(src_address), .src_read(src_read), .src_readdata(src_readdata),
    .src_waitrequest(src_waitrequest),
    .f_address(f_address), .f_write(f_write), .f_writedata(f_writedata), .f_read(f_read),
    .f_readdata(f_readdata), .f_waitrequest(f_waitrequest),
    .dst_address(dst_address), .dst_write(dst_write), .dst_writedata(dst_writedata),
    .dst_waitrequest(dst_waitrequest)
`ifdef WINDOW_SEQ_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;  // 0 zero-wait, 1 random stalls, 2 filter read stalled 3 cycles
  logic [31:0] img [0:W*H-1];
  logic [31:0] fregs [0:8];
  logic [23:0] noise;
  logic [31:0] garbage;
  logic [7:0]  filt_sum;
  int rd_cnt;

  // Filter slave: result byte is sum of R+G over the 9 registers; during a stall the data is junk.
  always_comb begin
    filt_sum = 8'd0;
    for (int i = 0; i < 9; i++) filt_sum = filt_sum + fregs[i][7:0] + fregs[i][15:8];
  end
  assign f_readdata   = f_waitrequest ? garbage : {noise, filt_sum};
  assign src_readdata = img[src_address % (W*H)];

  // Slave wait-state driver, updated just after each rising edge.
  initial begin
    src_waitrequest = 1'b0; f_waitrequest = 1'b0; dst_waitrequest = 1'b0;
    garbage = 32'd0; noise = 24'hFFFFFF; rd_cnt = 0;
    forever begin
      @(posedge clk); #1;
      garbage = $urandom;
      noise   = (mode == 0) ? 24'hFFFFFF : 24'($urandom);
      src_waitrequest = 1'b0; f_waitrequest = 1'b0; dst_waitrequest = 1'b0;
      if (mode == 1) begin
        src_waitrequest = 1'($urandom_range(0, 1));
        f_waitrequest   = 1'($urandom_range(0, 1));
        dst_waitrequest = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        if (f_read && rd_cnt < 3) begin
          f_waitrequest = 1'b1;
          rd_cnt = rd_cnt + 1;
        end else if (!f_read) begin
          rd_cnt = 0;
        end
      end
    end
  end

  int unsigned src_q[$];
  logic [36:0] fw_q[$];
  logic [47:0] dst_q[$];
  int done_cnt = 0, onehot_err = 0, stab_err = 0, fread_cyc = 0;
  logic p_sr, p_sw, p_fw, p_fr, p_fwait, p_dw, p_dwait;
  logic [15:0] p_sa, p_da;
  logic [4:0]  p_fa;
  logic [31:0] p_fwd, p_dwd;

  // Bus monitor sampled mid-cycle: accepted transfers, one-hot strobes, stability under wait.
  always @(negedge clk) begin
    if (reset) begin
      p_sr = 1'b0; p_fw = 1'b0; p_fr = 1'b0; p_dw = 1'b0;
    end else begin
      if (int'(src_read) + int'(f_write) + int'(f_read) + int'(dst_write) > 1) onehot_err++;
      if (p_sr && p_sw && !(src_read && src_address == p_sa)) stab_err++;
      if (p_fw && p_fwait && !(f_write && f_address == p_fa && f_writedata == p_fwd)) stab_err++;
      if (p_fr && p_fwait && !(f_read && f_address == p_fa)) stab_err++;
      if (p_dw && p_dwait && !(dst_write && dst_address == p_da && dst_writedata == p_dwd)) stab_err++;
      if (src_read && !src_waitrequest) src_q.push_back(int'(src_address));
      if (f_write && !f_waitrequest) begin
        fw_q.push_back({f_address, f_writedata});
        if (f_address < 5'd9) fregs[f_address] = f_writedata;
      end
      if (f_read) fread_cyc++;
      if (dst_write && !dst_waitrequest) dst_q.push_back({dst_address, dst_writedata});
      if (done) begin
        done_cnt++;
`ifdef WINDOW_SEQ_CYCLE_COUNT_EN
        cc_at_done = cycle_count;
`endif
      end
      p_sr = src_read; p_sw = src_waitrequest; p_sa = src_address;
      p_fw = f_write; p_fr = f_read; p_fwait = f_waitrequest; p_fa = f_address; p_fwd = f_writedata;
      p_dw = dst_write; p_dwait = dst_waitrequest; p_da = dst_address; p_dwd = dst_writedata;
    end
  end

  int unsigned exp_src[$];
  logic [36:0] exp_fw[$];
  logic [47:0] exp_dst[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: every window in raster order, 9 pixel reads, 9 pushes, one stored filter byte.
  task automatic build_exp();
    int a, s;
    exp_src.delete(); exp_fw.delete(); exp_dst.delete();
    for (int r = 0; r <= H - 3; r++) begin
      for (int c = 0; c <= W - 3; c++) begin
        s = 0;
        for (int k = 0; k < 9; k++) begin
          a = (r + k / 3) * W + c + k % 3;
          exp_src.push_back(a);
          exp_fw.push_back({5'(k), 8'h00, img[a][23:0]});
          s = s + int'(img[a][7:0]) + int'(img[a][15:8]);
        end
        exp_dst.push_back({16'(r * (W - 2) + c), 24'h000000, 8'(s)});
      end
    end
  endtask

  task automatic clear_mon();
    src_q.delete(); fw_q.delete(); dst_q.delete();
    onehot_err = 0; stab_err = 0; fread_cyc = 0;
  endtask

  task automatic compare_frame(input string tag);
    chk({tag, "_src_n"}, 64'(src_q.size()), 64'(exp_src.size()));
    for (int i = 0; i < src_q.size() && i < exp_src.size(); i++)
      chk({tag, "_src_addr"}, 64'(src_q[i]), 64'(exp_src[i]));
    chk({tag, "_fw_n"}, 64'(fw_q.size()), 64'(exp_fw.size()));
    for (int i = 0; i < fw_q.size() && i < exp_fw.size(); i++)
      chk({tag, "_fw"}, 64'(fw_q[i]), 64'(exp_fw[i]));
    chk({tag, "_dst_n"}, 64'(dst_q.size()), 64'(exp_dst.size()));
    for (int i = 0; i < dst_q.size() && i < exp_dst.size(); i++)
      chk({tag, "_dst"}, 64'(dst_q[i]), 64'(exp_dst[i]));
    chk({tag, "_onehot"}, 64'(onehot_err), 64'd0);
    chk({tag, "_stable"}, 64'(stab_err), 64'd0);
  endtask

  task automatic run_frame(input string tag, input bit mid_start);
    int d0;
    d0 = done_cnt;
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_aborted_clr"}, 64'(aborted), 64'd0);
    for (int i = 0; i < 5000 && done_cnt == d0; i++) begin
      tick();
      if (mid_start && i == 30) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    tick(); tick(); tick();
    chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    compare_frame(tag);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < W * H; i++) img[i] = $urandom;
    for (int i = 0; i < 9; i++) fregs[i] = 32'd0;
    tick(); tick();
    chk("rst_outs", {busy, done, aborted, src_read, f_write, f_read, dst_write}, 7'd0);
    chk("rst_addr", {src_address, f_address, dst_address}, 37'd0);
    chk("rst_data", {f_writedata, dst_writedata}, 64'd0);
    reset = 1'b0;
    tick(); tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // Zero-wait frame with a marked pixel at address 5 and all-ones filter upper bits.
    mode = 0;
    img[5] = 32'hAB123456;
    build_exp();
    run_frame("zw", 1'b0);
    chk("zw_k4_data", 64'(fw_q.size() > 4 ? fw_q[4] : 37'd0), {5'd4, 32'h00123456});
`ifdef WINDOW_SEQ_CYCLE_COUNT_EN
    chk("cycle_count", 64'(cc_at_done), 64'd85);
`endif

    // Random stalls with new image; start pulsed mid-frame must be ignored.
    mode = 1;
    for (int i = 0; i < W * H; i++) img[i] = $urandom;
    build_exp();
    run_frame("rnd", 1'b1);

    // Filter read held off 3 cycles: result taken only on the accepting cycle.
    mode = 2;
    for (int i = 0; i < W * H; i++) img[i] = $urandom;
    build_exp();
    run_frame("fstall", 1'b0);
    chk("fstall_rd_cycles", 64'(fread_cyc), 64'(4 * (W - 2) * (H - 2)));

    // Abort during k=3 fetch of window 2.
    mode = 0;
    build_exp();
    clear_mon();
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 500 && !(src_read && src_q.size() == 21); i++) tick();
    chk("ab_reach", 64'(src_read), 64'd1);
    abort = 1'b1;
    tick(); tick();
    chk("ab_idle", 64'(busy), 64'd0);
    chk("ab_flag", 64'(aborted), 64'd1);
    chk("ab_src_done", 64'(src_q.size()), 64'd22);
    tick(); tick(); tick();
    abort = 1'b0;
    chk("ab_no_done", 64'(done_cnt - d0), 64'd0);
    chk("ab_dst_n", 64'(dst_q.size()), 64'd2);
    for (int i = 0; i < dst_q.size() && i < 2; i++) chk("ab_dst", 64'(dst_q[i]), 64'(exp_dst[i]));

    // Start together with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0; tick();
    chk("sa_ignored", 64'(busy), 64'd0);
    chk("sa_sticky", 64'(aborted), 64'd1);

    // Reset during STORE drops dst_write at once and leaves everything at zero.
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 500 && !dst_write; i++) tick();
    chk("rs_reach", 64'(dst_write), 64'd1);
    reset = 1'b1; #1;
    chk("rs_async", 64'(dst_write), 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rs_outs", {busy, done, aborted, src_read, f_write, f_read, dst_write}, 7'd0);
    chk("rs_addr", {src_address, f_address, dst_address}, 37'd0);
    chk("rs_no_done", 64'(done_cnt - d0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/image_window_sequencer.md
IMAGE_WINDOW_SEQUENCER -- requirements
Module: image_window_sequencer

Interface
REQ-001 Parameter IMG_WIDTH, default 8, image width in pixels (SHALL be >= 3).
REQ-002 Parameter IMG_HEIGHT, default 8, image height in pixels (SHALL be >= 3).
REQ-003 Parameter ADDR_W, default 16, word-address width of the src and dst ports.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE.
REQ-007 abort  in  1  level; terminates the frame at the next transaction boundary.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse after the last result write is accepted.
REQ-010 aborted  out  1  sticky; set on abort, cleared by an accepted start.
REQ-011 src_address/src_read/src_readdata/src_waitrequest  out ADDR_W / out 1 / in 32 / in 1  pixel-memory read master; data {8'h00,B,G,R}.
REQ-012 f_address/f_write/f_writedata/f_read/f_readdata/f_waitrequest  out 5 / out 1 / out 32 / out 1 / in 32 / in 1  master to the filter slave.
REQ-013 dst_address/dst_write/dst_writedata/dst_waitrequest  out ADDR_W / out 1 / out 32 / in 1  result-memory write master.

Function
REQ-014 Outputs are computed for every 3x3 window origin (r,c), r=0..IMG_HEIGHT-3, c=0..IMG_WIDTH-3, in raster order (c fastest).
REQ-015 States: IDLE, FETCH, PUSH, RESULT, STORE, NEXT, DONE.
REQ-016 IDLE: on start go to FETCH with r=c=k=0 and aborted cleared; all master strobes are low.
REQ-017 FETCH: drive src_read=1 and src_address=(r+k/3)*IMG_WIDTH+(c+k%3); hold until src_waitrequest=0, latch src_readdata[23:0], then go to PUSH.
REQ-018 PUSH: drive f_write=1, f_address=k, f_writedata={8'h00,latched}; hold until f_waitrequest=0; if k<8, increment k and go to FETCH, otherwise go to RESULT.
REQ-019 RESULT: drive f_read=1 with f_address=0 until f_waitrequest=0, then latch f_readdata[7:0] and go to STORE.
REQ-020 STORE: drive dst_write=1, dst_address=r*(IMG_WIDTH-2)+c, dst_writedata={24'h0,result}; hold until dst_waitrequest=0, then go to NEXT.
REQ-021 NEXT (1 cycle): set k=0 and advance c; on c wrap, set c=0 and increment r; after the last window go to DONE, otherwise go to FETCH.
REQ-022 DONE (1 cycle): assert done=1, then go to IDLE.
REQ-023 All address, data and strobe outputs are registered and stay stable while the matching waitrequest is high.
REQ-024 At most one master strobe is high in any cycle.
REQ-025 Abort in FETCH/PUSH/RESULT/STORE takes effect on the cycle the current handshake completes; in NEXT it takes effect immediately; the block goes to IDLE and sets aborted, and done is not pulsed.
REQ-026 If start and abort are high together in IDLE, start is ignored.
REQ-027 Index arithmetic is unsigned and sized to ADDR_W; overflow is a parameterization error and is not handled.

Reset
REQ-028 While reset is high: state=IDLE; r, c, k and the latched data are 0; busy, done, aborted, src_read, f_write, f_read and dst_write are 0; all addresses and write data are 0.
REQ-029 Reset asserted mid-frame drops any in-flight strobe asynchronously; no done pulse is produced.

Configuration
REQ-030 With macro WINDOW_SEQ_CYCLE_COUNT_EN defined, a 32-bit output cycle_count exists; it clears on an accepted start, increments every cycle busy=1, holds at 0xFFFFFFFF, and resets to 0.
REQ-031 Without the macro, the port and the counter are absent and the remaining behaviour is identical.

Verification
REQ-032 IMG_WIDTH=4, IMG_HEIGHT=4, zero-wait memories, start -> first window src_address sequence 0,1,2,4,5,6,8,9,10 paired with f_address 0..8; exactly 4 dst writes at addresses 0,1,2,3; done pulses once.
REQ-033 Pixel word 0x00123456 at src 5 -> the f_writedata for k=4 of window (0,0) is 0x00123456; f_readdata=0xFFFFFF5A -> dst_writedata=0x0000005A.
REQ-034 f_waitrequest held high for 3 cycles during RESULT -> f_read and f_address stay stable for 4 cycles, and the result is latched only on the low cycle.
REQ-035 Abort asserted during the k=3 FETCH of window 2 -> the src handshake completes, the block returns to IDLE, aborted=1, done=0, and no further dst writes occur.
REQ-036 Start pulsed while busy -> no effect; reset asserted during STORE -> dst_write drops immediately and the block sits in IDLE with all outputs 0.
REQ-037 With WINDOW_SEQ_CYCLE_COUNT_EN, 4x4 frame, zero-wait memories -> cycle_count at done equals 4*(9*2+3)+1=85.
